full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder_pkg.sv | 13 +
 rtl/full_adder_bit.sv | 14 +
 rtl/full_adder.sv | 81 ++++++++
 tb/tb_full_adder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants for the ripple-carry full adder: default operand width
// and the legal width range enforced when the top module elaborates.
package full_adder_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int MIN_WIDTH     = 1;
  localparam int MAX_WIDTH     = 64;

  function automatic bit width_ok(input int width);
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full-adder cell; the top module chains WIDTH of
// these so each cell's carry-out feeds the next cell's carry-in.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder producing {cout,sum} = a + b + cin, with an
// optional output register stage (REG_OUT=1) giving exactly one cycle of latency.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("full_adder: WIDTH=%0d outside legal range %0d..%0d",
           WIDTH, MIN_WIDTH, MAX_WIDTH);
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_bit u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum_comb[i]),
      .cout (carry[i+1])
    );
  end

  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             valid_d, valid_q;

    // Invalid cycles keep the last result so junk on a/b/cin never reaches the outputs.
    always_comb begin
      sum_d   = sum_q;
      cout_d  = cout_q;
      valid_d = in_valid;
      if (in_valid) begin
        sum_d  = sum_comb;
        cout_d = carry[WIDTH];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        cout_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        cout_q  <= cout_d;
        valid_q <= valid_d;
      end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    // Clock and reset have no role in the purely combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign sum       = sum_comb;
    assign cout      = carry[WIDTH];
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: directed checks on 1-bit and 8-bit
// builds plus a randomized 16-bit registered stream with a scoreboard.
`timescale 1ns/1ps
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // 1-bit combinational instance
  logic c1_a = 0, c1_b = 0, c1_cin = 0, c1_iv = 0;
  logic [0:0] c1_sum;
  logic c1_cout, c1_ov;

  // 1-bit registered instance
  logic r1_a = 0, r1_b = 0, r1_cin = 0, r1_iv = 0;
  logic [0:0] r1_sum;
  logic r1_cout, r1_ov;

  // 8-bit registered instance
  logic [7:0] w8_a = 0, w8_b = 0;
  logic w8_cin = 0, w8_iv = 0;
  logic [7:0] w8_sum;
  logic w8_cout, w8_ov;

  // 16-bit registered instance under the scoreboard
  logic [15:0] w16_a = 0, w16_b = 0;
  logic w16_cin = 0, w16_iv = 0;
  logic [15:0] w16_sum;
  logic w16_cout, w16_ov;

  int total = 0;
  int bad = 0;

  logic [16:0] exp_q[$];

  full_adder #(.WIDTH(1), .REG_OUT(0)) u_comb1 (
    .clk(clk), .rst_n(rst_n), .a(c1_a), .b(c1_b), .cin(c1_cin), .in_valid(c1_iv),
    .sum(c1_sum), .cout(c1_cout), .out_valid(c1_ov));

  full_adder #(.WIDTH(1), .REG_OUT(1)) u_reg1 (
    .clk(clk), .rst_n(rst_n), .a(r1_a), .b(r1_b), .cin(r1_cin), .in_valid(r1_iv),
    .sum(r1_sum), .cout(r1_cout), .out_valid(r1_ov));

  full_adder #(.WIDTH(8), .REG_OUT(1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(w8_a), .b(w8_b), .cin(w8_cin), .in_valid(w8_iv),
    .sum(w8_sum), .cout(w8_cout), .out_valid(w8_ov));

  full_adder #(.WIDTH(16), .REG_OUT(1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .a(w16_a), .b(w16_b), .cin(w16_cin), .in_valid(w16_iv),
    .sum(w16_sum), .cout(w16_cout), .out_valid(w16_ov));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one 16-bit vector at the falling edge; valid vectors get their sum queued.
  task automatic applyStimulus(input bit v, input logic [15:0] av, input logic [15:0] bv,
                               input logic cv);
    @(negedge clk);
    w16_iv  = v;
    w16_a   = av;
    w16_b   = bv;
    w16_cin = cv;
    if (v && rst_n)
      exp_q.push_back(17'(av) + 17'(bv) + 17'(cv));
  endtask

  // Monitor: one-cycle-late view of in_valid decides whether a result is due.
  logic [16:0] held = '0;
  logic [16:0] mon_exp;
  bit mon_pend;

  always begin
    @(posedge clk);
    mon_pend = (rst_n === 1'b1) && (w16_iv === 1'b1);
    #1;
    if (rst_n !== 1'b1) begin
      checkOutput("w16_rst_ov", 64'(w16_ov), 64'd0);
      checkOutput("w16_rst_res", 64'({w16_cout, w16_sum}), 64'd0);
      held = '0;
      exp_q.delete();
    end else if (mon_pend) begin
      checkOutput("w16_ov_due", 64'(w16_ov), 64'd1);
      if (exp_q.size() == 0) begin
        checkOutput("w16_sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("w16_result", 64'({w16_cout, w16_sum}), 64'(mon_exp));
        held = mon_exp;
      end
    end else begin
      checkOutput("w16_ov_idle", 64'(w16_ov), 64'd0);
      checkOutput("w16_hold", 64'({w16_cout, w16_sum}), 64'(held));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  v3;
    logic [1:0]  tot2;
    logic [8:0]  tot9;
    logic [15:0] ra, rb;
    logic [7:0]  a8 [5];
    logic [7:0]  b8 [5];
    logic        ci8 [5];

    // Reset state, before any clock edge has been seen
    #2;
    checkOutput("r1_rst", 64'({r1_ov, r1_cout, r1_sum}), 64'd0);
    checkOutput("w8_rst", 64'({w8_ov, w8_cout, w8_sum}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Registered outputs must stay idle until a valid cycle is captured
    @(posedge clk); #1;
    checkOutput("r1_post_rst_ov", 64'(r1_ov), 64'd0);
    checkOutput("w8_post_rst_ov", 64'(w8_ov), 64'd0);

    // Exhaustive 1-bit combinational truth table
    for (int i = 0; i < 8; i++) begin
      v3 = 3'(i);
      c1_a = v3[2]; c1_b = v3[1]; c1_cin = v3[0]; c1_iv = 1'b1;
      tot2 = 2'(c1_a) + 2'(c1_b) + 2'(c1_cin);
      #5;
      checkOutput($sformatf("c1_sum_%0d", i), 64'(c1_sum), 64'(tot2[0]));
      checkOutput($sformatf("c1_cout_%0d", i), 64'(c1_cout), 64'(tot2[1]));
      #5;
    end
    checkOutput("c1_ov_follow", 64'(c1_ov), 64'd1);
    c1_iv = 1'b0;
    #1;
    checkOutput("c1_ov_low", 64'(c1_ov), 64'd0);

    // 1-bit registered latency, then hold on an invalid cycle
    @(negedge clk);
    r1_iv = 1'b1; r1_a = 1'b1; r1_b = 1'b1; r1_cin = 1'b1;
    @(posedge clk); #1;
    checkOutput("r1_lat", 64'({r1_ov, r1_cout, r1_sum}), 64'b111);
    @(negedge clk);
    r1_iv = 1'b0; r1_a = 1'($urandom); r1_b = 1'b0; r1_cin = 1'b0;
    @(posedge clk); #1;
    checkOutput("r1_hold", 64'({r1_ov, r1_cout, r1_sum}), 64'b011);

    // 8-bit carry-chain boundary cases plus two random vectors
    a8[0] = 8'hFF; b8[0] = 8'h00; ci8[0] = 1'b1;
    a8[1] = 8'hFF; b8[1] = 8'hFF; ci8[1] = 1'b1;
    a8[2] = 8'h00; b8[2] = 8'h00; ci8[2] = 1'b0;
    a8[3] = 8'($urandom); b8[3] = 8'($urandom); ci8[3] = 1'($urandom);
    a8[4] = 8'($urandom); b8[4] = 8'($urandom); ci8[4] = 1'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      w8_iv = 1'b1; w8_a = a8[i]; w8_b = b8[i]; w8_cin = ci8[i];
      tot9 = 9'(a8[i]) + 9'(b8[i]) + 9'(ci8[i]);
      @(posedge clk); #1;
      checkOutput($sformatf("w8_res_%0d", i), 64'({w8_cout, w8_sum}), 64'(tot9));
      checkOutput($sformatf("w8_ov_%0d", i), 64'(w8_ov), 64'd1);
    end
    @(negedge clk);
    w8_iv = 1'b0; w8_a = 8'($urandom); w8_b = 8'($urandom); w8_cin = 1'($urandom);
    @(posedge clk); #1;
    checkOutput("w8_hold_ov", 64'(w8_ov), 64'd0);
    checkOutput("w8_hold_res", 64'({w8_cout, w8_sum}), 64'(tot9));

    // Randomized 16-bit stream with a mid-stream asynchronous reset
    for (int n = 0; n < 10000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 9))
        0: ra = 16'hFFFF;
        1: rb = 16'hFFFF;
        default: ;
      endcase
      applyStimulus(($urandom_range(0, 2) != 0), ra, rb, 1'($urandom));
      if (n == 5000) begin
        applyStimulus(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ov", 64'(w16_ov), 64'd0);
        checkOutput("async_rst_res", 64'({w16_cout, w16_sum}), 64'd0);
        @(negedge clk);
        w16_iv = 1'b1; w16_a = 16'($urandom); w16_b = 16'($urandom); w16_cin = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        w16_iv = 1'b0;
      end
    end
    applyStimulus(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    applyStimulus(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    @(posedge clk); #2;
    checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
